// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing blocks: decoder FSM states,
// count-width helper and the LFSR seed shared with the stochastic number generator.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } dec_state_t;

  // Seed of the generator's 8-bit LFSR, kept here so loopback benches can rebuild its stream.
  localparam logic [7:0] SC_LFSR_SEED = 8'hA5;

  // Bits needed to hold a ones count of 0..bsl inclusive.
  function automatic int dec_out_w(input int bsl);
    return $clog2(bsl + 1);
  endfunction

endpackage

// File: rtl/sbs_decoder_if.sv
// Request/response bundle between an SC datapath (master) and the sbs_decoder (slave).
interface sbs_decoder_if #(
  parameter int BSL   = 255,
  parameter int OUT_W = 8
) ();

  // start is a one-cycle request, honoured only while busy is low; sbs_in is sampled on that cycle.
  // count transfers on every edge with out_valid && out_ready; out_valid and count hold until then.
  logic             start;
  logic [BSL-1:0]   sbs_in;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] count;

  modport master (
    output start, sbs_in, out_ready,
    input  busy, out_valid, count
  );

  modport slave (
    input  start, sbs_in, out_ready,
    output busy, out_valid, count
  );

endinterface

// File: rtl/sbs_decoder_popcount.sv
// Combinational ones counter over a W-bit vector.
module popcount #(
  parameter int W    = 8,
  parameter int PC_W = $clog2(W + 1)
) (
  input  logic [W-1:0]    bits,
  output logic [PC_W-1:0] ones
);

  always_comb begin
    ones = '0;
    for (int i = 0; i < W; i++) begin
      ones = ones + PC_W'(bits[i]);
    end
  end

endmodule

// File: rtl/sbs_decoder.sv
// Stochastic-to-binary converter: counts the ones of a BSL-bit stream CHUNK bits per
// cycle and returns the total through a valid/ready handshake.
module sbs_decoder
  import sc_pkg::*;
#(
  parameter int BSL   = 255,
  parameter int CHUNK = 8,
  parameter int OUT_W = dec_out_w(BSL)
) (
  input  logic       clk,
  input  logic       rst,
  sbs_decoder_if.slave bus,
  output dec_state_t state_dbg
);

  localparam int N_STEPS = (BSL + CHUNK - 1) / CHUNK;
  // Padding the register to whole chunks keeps the top partial chunk zero-filled.
  localparam int SREG_W  = N_STEPS * CHUNK;
  localparam int STEP_W  = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int PC_W    = $clog2(CHUNK + 1);

  dec_state_t        state;
  dec_state_t        state_next;
  logic [SREG_W-1:0] sreg;
  logic [STEP_W-1:0] step;
  logic [OUT_W-1:0]  acc;
  logic [OUT_W-1:0]  count_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [PC_W-1:0]   chunk_ones;
  logic [OUT_W-1:0]  acc_sum;

  logic last_step;
  logic do_load;
  logic do_step;
  logic do_done;
  logic do_ack;

  popcount #(
    .W    (CHUNK),
    .PC_W (PC_W)
  ) u_popcount (
    .bits (sreg[CHUNK-1:0]),
    .ones (chunk_ones)
  );

  assign acc_sum   = acc + OUT_W'(chunk_ones);
  assign last_step = (step == STEP_W'(N_STEPS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start)     state_next = COUNT;
      COUNT:   if (last_step)     state_next = HOLD;
      HOLD:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Start is only looked at in IDLE, so a start during COUNT/HOLD (even on the ack edge) is dropped.
  always_comb begin
    do_load = 1'b0;
    do_step = 1'b0;
    do_done = 1'b0;
    do_ack  = 1'b0;
    case (state)
      IDLE:  do_load = bus.start;
      COUNT: begin
        do_step = 1'b1;
        do_done = last_step;
      end
      HOLD:  do_ack = bus.out_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg        <= '0;
      step        <= '0;
      acc         <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      busy_q <= (state_next != IDLE);
      if (do_load) begin
        sreg <= SREG_W'(bus.sbs_in);
        acc  <= '0;
        step <= '0;
      end
      if (do_step) begin
        sreg <= sreg >> CHUNK;
        acc  <= acc_sum;
        step <= step + STEP_W'(1);
      end
      if (do_done) begin
        count_q     <= acc_sum;
        out_valid_q <= 1'b1;
      end
      if (do_ack) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.count     = count_q;
  assign state_dbg     = state;

endmodule
